// File: rtl/fetch_bus_responder.sv
// Halfword-wide memory responder on the 16-bit fetch bus: decodes the request,
// inserts WAIT_STATES wait cycles, then returns data with a one-cycle ack pulse.
module fetch_bus_responder #(
   parameter int          ADDR_BITS   = 10,
   parameter logic [63:0] BASE        = 64'hFFFF_FFFF_FFFF_F800,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [63:0] adr_i,
   input  logic [1:0]  size_i,
   input  logic        vpa_i,
   input  logic        we_i,
   input  logic [15:0] dat_i,
   output logic [15:0] dat_o,
   output logic        ack_o,
   output logic        err_o
);

   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT      = 2'd1;
   localparam logic [1:0] ACK       = 2'd2;
   localparam logic [1:0] SZ_IDLE   = 2'b00;
   localparam logic [1:0] SZ_BYTE   = 2'b01;
   localparam logic [1:0] SZ_HALF   = 2'b10;
   localparam logic [1:0] SZ_BAD    = 2'b11;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   logic [1:0]           state_r;
   logic [1:0]           state_nxt_s;
   logic [3:0]           cnt_r;
   logic [3:0]           cnt_nxt_s;
   logic                 capture_s;
   logic [63:0]          adr_r;
   logic [1:0]           size_r;
   logic                 we_r;
   logic                 vpa_r;
   logic [15:0]          wdat_r;
   logic [ADDR_BITS-1:0] index_s;
   logic                 lane_s;
   logic                 err_s;
   logic                 wr_en_s;
   logic [15:0]          rd_word_s;
   logic [15:0]          rd_data_s;
   logic [15:0]          mem [0:DEPTH-1];

   // Miss, illegal size, misaligned halfword, or a write flagged as opcode fetch.
   function automatic logic req_error(input logic [63:0] adr, input logic [1:0] size,
                                      input logic we, input logic vpa);
      logic miss;
      miss = (adr[63:ADDR_BITS+1] != BASE[63:ADDR_BITS+1]);
      return miss | (size == SZ_BAD) | ((size == SZ_HALF) & adr[0]) | (we & vpa);
   endfunction

   assign index_s   = adr_r[ADDR_BITS:1];
   assign lane_s    = adr_r[0];
   assign err_s     = req_error(adr_r, size_r, we_r, vpa_r);
   assign wr_en_s   = (state_r == ACK) & we_r & ~err_s;
   assign rd_word_s = mem[index_s];

   // Read data selection for the captured request.
   always_comb begin
      rd_data_s = 16'h0000;
      case (size_r)
         SZ_HALF: rd_data_s = rd_word_s;
         SZ_BYTE: begin
            if (lane_s) begin
               rd_data_s = {8'h00, rd_word_s[15:8]};
            end else begin
               rd_data_s = {8'h00, rd_word_s[7:0]};
            end
         end
         default: rd_data_s = 16'h0000;
      endcase
   end

   // Next-state logic; a dropped request during WAIT aborts without ack.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      capture_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (size_i != SZ_IDLE) begin
               capture_s = 1'b1;
               cnt_nxt_s = WAIT_LOAD;
               if (WAIT_LOAD == 4'd0) begin
                  state_nxt_s = ACK;
               end else begin
                  state_nxt_s = WAIT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (size_i == SZ_IDLE) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 4'd0;
            end else if (cnt_r == 4'd1) begin
               state_nxt_s = ACK;
               cnt_nxt_s   = 4'd0;
            end else begin
               state_nxt_s = WAIT;
               cnt_nxt_s   = cnt_r - 4'd1;
            end
         end
         ACK: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // State, wait counter and request capture registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         adr_r   <= 64'd0;
         size_r  <= SZ_IDLE;
         we_r    <= 1'b0;
         vpa_r   <= 1'b0;
         wdat_r  <= 16'h0000;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (capture_s) begin
            adr_r  <= adr_i;
            size_r <= size_i;
            we_r   <= we_i;
            vpa_r  <= vpa_i;
            wdat_r <= dat_i;
         end
      end
   end

   // Registered response; the pulse is produced on the edge that ends ACK.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         dat_o <= 16'h0000;
      end else if (state_r == ACK) begin
         ack_o <= 1'b1;
         err_o <= err_s;
         dat_o <= (err_s | we_r) ? 16'h0000 : rd_data_s;
      end else begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         dat_o <= 16'h0000;
      end
   end

   // Memory array is never reset so contents survive reset_n_i.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         case (size_r)
            SZ_HALF: mem[index_s] <= wdat_r;
            SZ_BYTE: begin
               if (lane_s) begin
                  mem[index_s][15:8] <= wdat_r[7:0];
               end else begin
                  mem[index_s][7:0] <= wdat_r[7:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_bus_responder.sv
// Directed bench: one responder with no wait states and one with three,
// sharing clock, reset, address and data but with separate size strobes.
module tb_fetch_bus_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] adr = 64'd0;
   logic [1:0]  size0 = 2'b00;
   logic [1:0]  size3 = 2'b00;
   logic        vpa = 1'b0;
   logic        we = 1'b0;
   logic [15:0] dat = 16'h0000;
   logic [15:0] dat0, dat3;
   logic        ack0, ack3, err0, err3;
   int          checks = 0;
   int          errors = 0;

   localparam logic [63:0] A_FF00 = 64'hFFFF_FFFF_FFFF_FF00;
   localparam logic [63:0] A_FF01 = 64'hFFFF_FFFF_FFFF_FF01;
   localparam logic [63:0] A_FF02 = 64'hFFFF_FFFF_FFFF_FF02;
   localparam logic [63:0] A_FF10 = 64'hFFFF_FFFF_FFFF_FF10;
   localparam logic [63:0] A_FF11 = 64'hFFFF_FFFF_FFFF_FF11;
   localparam logic [63:0] A_FF20 = 64'hFFFF_FFFF_FFFF_FF20;

   fetch_bus_responder #(.WAIT_STATES(0)) dut0 (
      .clk_i(clk), .reset_n_i(reset_n), .adr_i(adr), .size_i(size0), .vpa_i(vpa),
      .we_i(we), .dat_i(dat), .dat_o(dat0), .ack_o(ack0), .err_o(err0));

   fetch_bus_responder #(.WAIT_STATES(3)) dut3 (
      .clk_i(clk), .reset_n_i(reset_n), .adr_i(adr), .size_i(size3), .vpa_i(vpa),
      .we_i(we), .dat_i(dat), .dat_o(dat3), .ack_o(ack3), .err_o(err3));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request to the selected responder and waits (bounded) for its ack.
   task automatic xfer(input bit sel, input logic [63:0] a, input logic [1:0] sz,
                       input logic w, input logic v, input logic [15:0] d,
                       output logic [15:0] rd, output logic er, output int lat);
      adr = a; we = w; vpa = v; dat = d;
      if (sel) size3 = sz; else size0 = sz;
      lat = 0; rd = 16'h0000; er = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (sel ? ack3 : ack0) begin
            lat = i;
            rd  = sel ? dat3 : dat0;
            er  = sel ? err3 : err0;
            break;
         end
      end
      size0 = 2'b00; size3 = 2'b00; we = 1'b0; vpa = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      checks++;
      if (ack0 !== 1'b0 || err0 !== 1'b0 || dat0 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_dut0 got ack=%b err=%b dat=%h want 0 0 0000", ack0, err0, dat0);
      end
      checks++;
      if (ack3 !== 1'b0 || err3 !== 1'b0 || dat3 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_dut3 got ack=%b err=%b dat=%h want 0 0 0000", ack3, err3, dat3);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      logic [15:0] rd; logic er; int lat;
      xfer(1'b0, A_FF00, 2'b10, 1'b1, 1'b0, 16'hAAAA, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 16'h0000) begin
         errors++;
         $display("FAIL wr_ff00 got lat=%0d err=%b dat=%h want 2 0 0000", lat, er, rd);
      end
      xfer(1'b0, A_FF02, 2'b10, 1'b1, 1'b0, 16'hBBBB, rd, er, lat);
      xfer(1'b1, A_FF00, 2'b10, 1'b1, 1'b0, 16'hAAAA, rd, er, lat);
      checks++;
      if (lat !== 5 || er !== 1'b0) begin
         errors++;
         $display("FAIL wr_ff00_ws3 got lat=%0d err=%b want 5 0", lat, er);
      end
      xfer(1'b0, A_FF00, 2'b10, 1'b0, 1'b1, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 16'hAAAA) begin
         errors++;
         $display("FAIL rd_ff00 got lat=%0d err=%b dat=%h want 2 0 aaaa", lat, er, rd);
      end
      xfer(1'b0, A_FF02, 2'b10, 1'b0, 1'b1, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 16'hBBBB) begin
         errors++;
         $display("FAIL rd_ff02 got lat=%0d err=%b dat=%h want 2 0 bbbb", lat, er, rd);
      end
   endtask

   task automatic test_fetch();
      logic [31:0] ir = 32'h0;
      logic a1, a2;
      adr = A_FF00; vpa = 1'b1; we = 1'b0; size0 = 2'b10;
      tick();
      tick();
      a1 = ack0; ir[15:0] = dat0;
      adr = A_FF02;
      tick();
      tick();
      a2 = ack0; ir[31:16] = dat0;
      size0 = 2'b00; vpa = 1'b0;
      checks++;
      if (a1 !== 1'b1 || a2 !== 1'b1 || ir !== 32'hBBBBAAAA) begin
         errors++;
         $display("FAIL fetch32 got acks=%b%b ir=%h want 11 bbbbaaaa", a1, a2, ir);
      end
      tick();
   endtask

   task automatic test_byte_lanes();
      logic [15:0] rd; logic er; int lat;
      xfer(1'b0, A_FF10, 2'b10, 1'b1, 1'b0, 16'h1234, rd, er, lat);
      xfer(1'b0, A_FF11, 2'b01, 1'b1, 1'b0, 16'hABCD, rd, er, lat);
      xfer(1'b0, A_FF10, 2'b10, 1'b0, 1'b0, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 16'hCD34) begin
         errors++;
         $display("FAIL hw_ff10 got lat=%0d err=%b dat=%h want 2 0 cd34", lat, er, rd);
      end
      xfer(1'b0, A_FF10, 2'b01, 1'b0, 1'b0, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 16'h0034) begin
         errors++;
         $display("FAIL byte_ff10 got lat=%0d err=%b dat=%h want 2 0 0034", lat, er, rd);
      end
      xfer(1'b0, A_FF11, 2'b01, 1'b0, 1'b0, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 16'h00CD) begin
         errors++;
         $display("FAIL byte_ff11 got lat=%0d err=%b dat=%h want 2 0 00cd", lat, er, rd);
      end
   endtask

   task automatic test_wait_states();
      logic        exp_ack;
      logic [15:0] exp_dat;
      adr = A_FF00; vpa = 1'b1; we = 1'b0; size3 = 2'b10;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_ack = (i == 5);
         exp_dat = (i == 5) ? 16'hAAAA : 16'h0000;
         checks++;
         if (ack3 !== exp_ack || dat3 !== exp_dat || err3 !== 1'b0) begin
            errors++;
            $display("FAIL ws3_cycle%0d got ack=%b err=%b dat=%h want %b 0 %h",
                     i, ack3, err3, dat3, exp_ack, exp_dat);
         end
         if (i == 5) begin
            size3 = 2'b00; vpa = 1'b0;
         end
      end
   endtask

   task automatic test_errors();
      logic [15:0] rd; logic er; int lat;
      xfer(1'b0, 64'd0, 2'b10, 1'b0, 1'b0, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b1 || rd !== 16'h0000) begin
         errors++;
         $display("FAIL err_miss got lat=%0d err=%b dat=%h want 2 1 0000", lat, er, rd);
      end
      xfer(1'b0, A_FF01, 2'b10, 1'b0, 1'b0, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b1 || rd !== 16'h0000) begin
         errors++;
         $display("FAIL err_misaligned got lat=%0d err=%b dat=%h want 2 1 0000", lat, er, rd);
      end
      xfer(1'b0, A_FF00, 2'b11, 1'b1, 1'b0, 16'h1111, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b1 || rd !== 16'h0000) begin
         errors++;
         $display("FAIL err_size11 got lat=%0d err=%b dat=%h want 2 1 0000", lat, er, rd);
      end
      xfer(1'b0, A_FF00, 2'b10, 1'b1, 1'b1, 16'h5555, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b1 || rd !== 16'h0000) begin
         errors++;
         $display("FAIL err_we_vpa got lat=%0d err=%b dat=%h want 2 1 0000", lat, er, rd);
      end
      xfer(1'b0, A_FF00, 2'b10, 1'b0, 1'b1, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 16'hAAAA) begin
         errors++;
         $display("FAIL err_readback got lat=%0d err=%b dat=%h want 2 0 aaaa", lat, er, rd);
      end
   endtask

   task automatic test_abort();
      logic [15:0] rd; logic er; int lat;
      logic any_ack = 1'b0;
      xfer(1'b1, A_FF20, 2'b10, 1'b1, 1'b0, 16'h1111, rd, er, lat);
      adr = A_FF20; we = 1'b1; vpa = 1'b0; dat = 16'h2222; size3 = 2'b10;
      tick();
      tick();
      size3 = 2'b00; we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         any_ack = any_ack | ack3;
      end
      checks++;
      if (any_ack !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_ack got ack seen=%b want 0", any_ack);
      end
      xfer(1'b1, A_FF20, 2'b10, 1'b0, 1'b0, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 5 || er !== 1'b0 || rd !== 16'h1111) begin
         errors++;
         $display("FAIL abort_readback got lat=%0d err=%b dat=%h want 5 0 1111", lat, er, rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd; logic er; int lat;
      adr = A_FF00; vpa = 1'b1; we = 1'b0; size0 = 2'b10;
      tick();
      tick();
      checks++;
      if (ack0 !== 1'b1 || dat0 !== 16'hAAAA) begin
         errors++;
         $display("FAIL pre_reset_ack got ack=%b dat=%h want 1 aaaa", ack0, dat0);
      end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (ack0 !== 1'b0 || err0 !== 1'b0 || dat0 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_clears got ack=%b err=%b dat=%h want 0 0 0000", ack0, err0, dat0);
      end
      size0 = 2'b00; vpa = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      adr = A_FF00; we = 1'b1; dat = 16'h3333; size3 = 2'b10;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      size3 = 2'b00; we = 1'b0;
      tick();
      tick();
      checks++;
      if (ack3 !== 1'b0 || dat3 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_in_wait got ack=%b dat=%h want 0 0000", ack3, dat3);
      end
      reset_n = 1'b1;
      xfer(1'b1, A_FF00, 2'b10, 1'b0, 1'b1, 16'h0000, rd, er, lat);
      checks++;
      if (lat !== 5 || er !== 1'b0 || rd !== 16'hAAAA) begin
         errors++;
         $display("FAIL post_reset_read got lat=%0d err=%b dat=%h want 5 0 aaaa", lat, er, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] mask0 = 6'd0;
      logic [9:0] mask3 = 10'd0;
      adr = A_FF02; vpa = 1'b1; we = 1'b0; size0 = 2'b10;
      for (int i = 0; i < 6; i++) begin
         tick();
         mask0[i] = ack0;
      end
      size0 = 2'b00;
      tick();
      checks++;
      if (mask0 !== 6'b101010) begin
         errors++;
         $display("FAIL b2b_ws0 got ack pattern=%b want 101010", mask0);
      end
      size3 = 2'b10;
      for (int i = 0; i < 10; i++) begin
         tick();
         mask3[i] = ack3;
      end
      size3 = 2'b00; vpa = 1'b0;
      tick();
      checks++;
      if (mask3 !== 10'b1000010000) begin
         errors++;
         $display("FAIL b2b_ws3 got ack pattern=%b want 1000010000", mask3);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_fetch();
      test_byte_lanes();
      test_wait_states();
      test_errors();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
